// File: rtl/rvx_timer_pkg.sv
// Shared definitions for the multichannel timer: register indices and CTRL layout.
package rvx_timer_pkg;

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_PRESCALE = 2'd1,
    REG_COMPARE  = 2'd2,
    REG_COUNT    = 2'd3
  } reg_index_e;

  localparam int CTRL_ENABLE_BIT     = 0;
  localparam int CTRL_PERIODIC_BIT   = 1;
  localparam int CTRL_IRQ_ENABLE_BIT = 2;
  localparam int CTRL_FLAG_BIT       = 3;
  localparam int CTRL_WIDTH          = 4;

  // Member order puts enable at bit 0, matching the CTRL bit positions above.
  typedef struct packed {
    logic flag;
    logic irq_enable;
    logic periodic;
    logic enable;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    return {{(32 - CTRL_WIDTH){1'b0}}, c};
  endfunction

endpackage

// File: rtl/rvx_timer_channel.sv
// One timer channel: CTRL/PRESCALE/COMPARE/COUNT registers, prescaler and match logic.
module rvx_timer_channel
  import rvx_timer_pkg::*;
#(
  parameter int COUNTER_WIDTH   = 32,
  parameter int PRESCALER_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_strobe,
  input  reg_index_e  reg_index,
  input  logic [31:0] write_data,
  output logic [31:0] read_word,
  output logic        irq
);

  ctrl_t                      ctrl_reg, ctrl_next;
  logic [PRESCALER_WIDTH-1:0] prescale_reg, prescale_next;
  logic [PRESCALER_WIDTH-1:0] pcnt_reg, pcnt_next;
  logic [COUNTER_WIDTH-1:0]   compare_reg, compare_next;
  logic [COUNTER_WIDTH-1:0]   count_reg, count_next;
  logic                       irq_reg, irq_next;
  logic                       wr_ctrl, wr_prescale, wr_compare, wr_count;
  logic                       tick, match;
  logic                       unused_write_bits;

  assign unused_write_bits = ^write_data;

  assign wr_ctrl     = write_strobe && (reg_index == REG_CTRL);
  assign wr_prescale = write_strobe && (reg_index == REG_PRESCALE);
  assign wr_compare  = write_strobe && (reg_index == REG_COMPARE);
  assign wr_count    = write_strobe && (reg_index == REG_COUNT);

  assign tick  = ctrl_reg.enable && (pcnt_reg == prescale_reg);
  assign match = tick && (count_reg == compare_reg);

  // A match outranks a same-cycle write-1-clear so no event is lost.
  always_comb begin
    ctrl_next = ctrl_reg;
    if (match && !ctrl_reg.periodic) begin
      ctrl_next.enable = 1'b0;
    end
    if (wr_ctrl) begin
      ctrl_next.enable     = write_data[CTRL_ENABLE_BIT];
      ctrl_next.periodic   = write_data[CTRL_PERIODIC_BIT];
      ctrl_next.irq_enable = write_data[CTRL_IRQ_ENABLE_BIT];
      if (write_data[CTRL_FLAG_BIT]) begin
        ctrl_next.flag = 1'b0;
      end
    end
    if (match) begin
      ctrl_next.flag = 1'b1;
    end
  end

  always_comb begin
    prescale_next = prescale_reg;
    compare_next  = compare_reg;
    if (wr_prescale) begin
      prescale_next = write_data[PRESCALER_WIDTH-1:0];
    end
    if (wr_compare) begin
      compare_next = write_data[COUNTER_WIDTH-1:0];
    end
  end

  // Software writes to COUNT take priority over a tick in the same cycle.
  always_comb begin
    count_next = count_reg;
    if (wr_count) begin
      count_next = write_data[COUNTER_WIDTH-1:0];
    end else if (tick) begin
      if (match) begin
        if (ctrl_reg.periodic) begin
          count_next = '0;
        end
      end else begin
        count_next = count_reg + COUNTER_WIDTH'(1);
      end
    end
  end

  // Starting from a disabled state always begins a fresh prescale period.
  always_comb begin
    pcnt_next = '0;
    if (ctrl_reg.enable && ctrl_next.enable && !tick && !wr_prescale) begin
      pcnt_next = pcnt_reg + PRESCALER_WIDTH'(1);
    end
  end

  assign irq_next = ctrl_next.flag && ctrl_next.irq_enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_reg     <= '0;
      prescale_reg <= '0;
      pcnt_reg     <= '0;
      compare_reg  <= '0;
      count_reg    <= '0;
      irq_reg      <= 1'b0;
    end else begin
      ctrl_reg     <= ctrl_next;
      prescale_reg <= prescale_next;
      pcnt_reg     <= pcnt_next;
      compare_reg  <= compare_next;
      count_reg    <= count_next;
      irq_reg      <= irq_next;
    end
  end

  always_comb begin
    read_word = '0;
    case (reg_index)
      REG_CTRL:     read_word = ctrl_word(ctrl_reg);
      REG_PRESCALE: read_word = 32'(prescale_reg);
      REG_COMPARE:  read_word = 32'(compare_reg);
      REG_COUNT:    read_word = 32'(count_reg);
      default:      read_word = '0;
    endcase
  end

  assign irq = irq_reg;

endmodule

// File: rtl/rvx_multichannel_timer.sv
// Multichannel timer top: address decode, read mux, response and interrupt aggregation.
module rvx_multichannel_timer
  import rvx_timer_pkg::*;
#(
  parameter int NUM_CHANNELS    = 4,
  parameter int COUNTER_WIDTH   = 32,
  parameter int PRESCALER_WIDTH = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [$clog2(NUM_CHANNELS)+1:0]   reg_address,
  input  logic                              reg_write_request,
  input  logic [31:0]                       reg_write_data,
  input  logic                              reg_read_request,
  output logic [31:0]                       reg_read_data,
  output logic                              reg_response,
  output logic [NUM_CHANNELS-1:0]           interrupt_vector,
  output logic                              interrupt
);

  localparam int ADDR_WIDTH = $clog2(NUM_CHANNELS) + 2;

  logic [ADDR_WIDTH-1:0]   chan_index;
  logic                    chan_valid;
  reg_index_e              reg_index;
  logic [31:0]             chan_read [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] chan_irq;
  logic [31:0]             read_mux;
  logic [31:0]             read_data_reg;
  logic                    response_reg;

  assign chan_index = reg_address >> 2;
  assign chan_valid = int'(chan_index) < NUM_CHANNELS;
  assign reg_index  = reg_index_e'(reg_address[1:0]);

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    logic chan_write;

    assign chan_write = reg_write_request && chan_valid && (int'(chan_index) == gi);

    rvx_timer_channel #(
      .COUNTER_WIDTH   (COUNTER_WIDTH),
      .PRESCALER_WIDTH (PRESCALER_WIDTH)
    ) u_channel (
      .clock        (clock),
      .reset        (reset),
      .write_strobe (chan_write),
      .reg_index    (reg_index),
      .write_data   (reg_write_data),
      .read_word    (chan_read[gi]),
      .irq          (chan_irq[gi])
    );
  end

  // Out-of-range channel indices fall through to zero.
  always_comb begin
    read_mux = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (chan_valid && (int'(chan_index) == i)) begin
        read_mux = chan_read[i];
      end
    end
  end

  // Sampling the mux before the write lands gives reads their pre-write value.
  always_ff @(posedge clock) begin
    if (reset) begin
      response_reg  <= 1'b0;
      read_data_reg <= '0;
    end else begin
      response_reg  <= reg_write_request || reg_read_request;
      read_data_reg <= reg_read_request ? read_mux : '0;
    end
  end

  assign reg_response     = response_reg && !reset;
  assign reg_read_data    = read_data_reg & {32{!reset}};
  assign interrupt_vector = chan_irq & {NUM_CHANNELS{!reset}};
  assign interrupt        = |interrupt_vector;

endmodule

// File: tb/tb_rvx_multichannel_timer.sv
// Self-checking bench: directed scenarios plus randomized register traffic vs. a reference model.
module tb_rvx_multichannel_timer;

  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int PW  = 4;
  localparam int AW  = $clog2(NCH) + 2;
  localparam logic [31:0] CMASK = 32'h0000_00FF;
  localparam logic [31:0] PMASK = 32'h0000_000F;
  localparam int R_CTRL = 0, R_PRESCALE = 1, R_COMPARE = 2, R_COUNT = 3;

  logic           clock;
  logic           reset;
  logic [AW-1:0]  reg_address;
  logic           reg_write_request;
  logic [31:0]    reg_write_data;
  logic           reg_read_request;
  logic [31:0]    reg_read_data;
  logic           reg_response;
  logic [NCH-1:0] interrupt_vector;
  logic           interrupt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic        m_en [NCH];
  logic        m_per [NCH];
  logic        m_ie [NCH];
  logic        m_flag [NCH];
  logic [31:0] m_ps [NCH];
  logic [31:0] m_cmp [NCH];
  logic [31:0] m_cnt [NCH];
  logic [31:0] m_phase [NCH];
  logic           exp_resp;
  logic [31:0]    exp_rdata;
  logic [NCH-1:0] exp_iv;

  rvx_multichannel_timer #(
    .NUM_CHANNELS    (NCH),
    .COUNTER_WIDTH   (CW),
    .PRESCALER_WIDTH (PW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .reg_address       (reg_address),
    .reg_write_request (reg_write_request),
    .reg_write_data    (reg_write_data),
    .reg_read_request  (reg_read_request),
    .reg_read_data     (reg_read_data),
    .reg_response      (reg_response),
    .interrupt_vector  (interrupt_vector),
    .interrupt         (interrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int c, input int r);
    case (r)
      R_CTRL:     return {28'd0, m_flag[c], m_ie[c], m_per[c], m_en[c]};
      R_PRESCALE: return m_ps[c];
      R_COMPARE:  return m_cmp[c];
      default:    return m_cnt[c];
    endcase
  endfunction

  task automatic model_clock(input bit rst, input bit wr, input bit rd,
                             input logic [AW-1:0] a, input logic [31:0] d);
    int ch;
    int r;
    bit ok;
    bit tick;
    bit hit;
    bit was_en;
    ch = int'(a >> 2);
    r  = int'(a[1:0]);
    ok = ch < NCH;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_flag[c] = 0;
        m_ps[c] = 0; m_cmp[c] = 0; m_cnt[c] = 0; m_phase[c] = 0;
      end
      exp_resp = 0; exp_rdata = 0; exp_iv = '0;
      return;
    end
    exp_resp  = wr || rd;
    exp_rdata = (rd && ok) ? model_read(ch, r) : 32'd0;
    for (int c = 0; c < NCH; c++) begin
      tick   = m_en[c] && (m_phase[c] == m_ps[c]);
      hit    = tick && (m_cnt[c] == m_cmp[c]);
      was_en = m_en[c];
      if (tick) m_phase[c] = 0;
      else if (m_en[c]) m_phase[c] = m_phase[c] + 1;
      if (hit) begin
        m_flag[c] = 1;
        if (m_per[c]) m_cnt[c] = 0;
        else m_en[c] = 0;
      end else if (tick) begin
        m_cnt[c] = (m_cnt[c] + 1) & CMASK;
      end
      if (wr && ok && ch == c) begin
        case (r)
          R_CTRL: begin
            m_en[c]  = d[0];
            m_per[c] = d[1];
            m_ie[c]  = d[2];
            if (d[3] && !hit) m_flag[c] = 0;
            if (d[0] && !was_en) m_phase[c] = 0;
          end
          R_PRESCALE: begin
            m_ps[c]    = d & PMASK;
            m_phase[c] = 0;
          end
          R_COMPARE: m_cmp[c] = d & CMASK;
          default:   m_cnt[c] = d & CMASK;
        endcase
      end
      if (!m_en[c]) m_phase[c] = 0;
      exp_iv[c] = m_flag[c] && m_ie[c];
    end
  endtask

  function automatic logic [AW-1:0] addr(input int c, input int r);
    return AW'((c << 2) | r);
  endfunction

  task automatic step(input bit rst, input bit wr, input bit rd,
                      input logic [AW-1:0] a, input logic [31:0] d);
    reset             = rst;
    reg_write_request = wr;
    reg_read_request  = rd;
    reg_address       = a;
    reg_write_data    = d;
    @(posedge clock);
    model_clock(rst, wr, rd, a, d);
    #1;
    if (wr || rd)
      $display("txn rst=%0b wr=%0b rd=%0b addr=%0d wdata=0x%08h resp=%0b rdata=0x%08h irq=%b",
               rst, wr, rd, a, d, reg_response, reg_read_data, interrupt_vector);
    check_value("resp", 32'(reg_response), 32'(exp_resp));
    check_value("rdata", reg_read_data, exp_rdata);
    check_value("irq_vec", 32'(interrupt_vector), 32'(exp_iv));
    check_value("irq_or", 32'(interrupt), 32'(|exp_iv));
  endtask

  task automatic wr_reg(input int c, input int r, input logic [31:0] d);
    step(0, 1, 0, addr(c, r), d);
  endtask

  task automatic rd_reg(input int c, input int r);
    step(0, 0, 1, addr(c, r), 32'd0);
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 32'd0);
  endtask

  logic [31:0] wrap_seq [8];

  initial begin
    reset = 1'b1; reg_address = '0; reg_write_request = 0; reg_read_request = 0; reg_write_data = 0;
    for (int c = 0; c < NCH; c++) model_clock(1, 0, 0, '0, 0);

    // Reset: outputs quiet even with a read pending, registers all zero afterwards
    step(1, 0, 0, '0, 0);
    step(1, 0, 1, addr(0, R_COUNT), 0);
    check_value("rst_resp", 32'(reg_response), 32'd0);
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++) begin
        rd_reg(c, r);
        check_value("rst_reg", reg_read_data, 32'd0);
      end

    // Ch0 periodic, PRESCALE=0, COMPARE=3: flag 4 cycles after enable, then every 4
    wr_reg(0, R_PRESCALE, 0);
    wr_reg(0, R_COMPARE, 3);
    wr_reg(0, R_CTRL, 32'h7);
    for (int k = 1; k <= 4; k++) begin
      idle();
      check_value("period_iv0", 32'(interrupt_vector[0]), 32'(k == 4));
    end
    wr_reg(0, R_CTRL, 32'hF);
    check_value("period_clr", 32'(interrupt_vector[0]), 32'd0);
    for (int k = 6; k <= 8; k++) begin
      idle();
      check_value("period_rpt", 32'(interrupt_vector[0]), 32'(k == 8));
    end
    wr_reg(0, R_CTRL, 32'h8);

    // Ch1 one-shot, PRESCALE=2, COMPARE=1: single match 6 cycles after enable
    wr_reg(1, R_PRESCALE, 2);
    wr_reg(1, R_COMPARE, 1);
    wr_reg(1, R_CTRL, 32'h5);
    for (int k = 1; k <= 6; k++) begin
      idle();
      check_value("oneshot_iv1", 32'(interrupt_vector[1]), 32'(k == 6));
    end
    rd_reg(1, R_CTRL);
    check_value("oneshot_ctrl", reg_read_data, 32'hC);
    for (int k = 0; k < 5; k++) idle();
    rd_reg(1, R_COUNT);
    check_value("oneshot_hold", reg_read_data, 32'd1);
    wr_reg(1, R_CTRL, 32'h8);

    // Ch2 wrap: COUNT=0xFE, COMPARE=5, periodic -> no flag at wrap, flag at 5
    wrap_seq = '{32'hFE, 32'hFF, 32'h00, 32'h01, 32'h02, 32'h03, 32'h04, 32'h05};
    wr_reg(2, R_COMPARE, 5);
    wr_reg(2, R_PRESCALE, 0);
    wr_reg(2, R_COUNT, 32'hFE);
    wr_reg(2, R_CTRL, 32'h7);
    for (int k = 1; k <= 8; k++) begin
      rd_reg(2, R_COUNT);
      check_value("wrap_count", reg_read_data, wrap_seq[k-1]);
      check_value("wrap_iv2", 32'(interrupt_vector[2]), 32'(k == 8));
    end
    wr_reg(2, R_CTRL, 32'h8);

    // Ch3: W1C on the match cycle loses to the set, the next W1C clears
    wr_reg(3, R_PRESCALE, 0);
    wr_reg(3, R_COMPARE, 2);
    wr_reg(3, R_CTRL, 32'h7);
    idle();
    idle();
    wr_reg(3, R_CTRL, 32'hF);
    check_value("setwins_iv3", 32'(interrupt_vector[3]), 32'd1);
    wr_reg(3, R_CTRL, 32'hF);
    check_value("w1c_iv3", 32'(interrupt_vector[3]), 32'd0);
    check_value("w1c_irq", 32'(interrupt), 32'd0);
    wr_reg(3, R_CTRL, 32'h8);

    // COUNT write on a tick cycle wins; then reset mid-count
    wr_reg(0, R_COMPARE, 200);
    wr_reg(0, R_CTRL, 32'h3);
    idle();
    idle();
    wr_reg(0, R_COUNT, 32'h40);
    rd_reg(0, R_COUNT);
    check_value("cntwr_wins", reg_read_data, 32'h40);
    rd_reg(0, R_COUNT);
    check_value("cntwr_next", reg_read_data, 32'h41);
    step(1, 0, 1, addr(0, R_COUNT), 0);
    check_value("midrst_resp", 32'(reg_response), 32'd0);
    check_value("midrst_rdata", reg_read_data, 32'd0);
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++) begin
        rd_reg(c, r);
        check_value("midrst_reg", reg_read_data, 32'd0);
      end

    // Out-of-range channel, read/write collision, width truncation
    rd_reg(7, R_COUNT);
    check_value("oor_resp", 32'(reg_response), 32'd1);
    check_value("oor_rdata", reg_read_data, 32'd0);
    wr_reg(6, R_COMPARE, 32'h55);
    wr_reg(4, R_COMPARE, 32'h11);
    step(0, 1, 1, addr(4, R_COMPARE), 32'h22);
    check_value("rw_prewrite", reg_read_data, 32'h11);
    rd_reg(4, R_COMPARE);
    check_value("rw_postwrite", reg_read_data, 32'h22);
    wr_reg(4, R_COUNT, 32'hABCD_1234);
    rd_reg(4, R_COUNT);
    check_value("trunc_count", reg_read_data, 32'h34);
    wr_reg(4, R_PRESCALE, 32'hFFFF_FFF7);
    rd_reg(4, R_PRESCALE);
    check_value("trunc_ps", reg_read_data, 32'h7);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int kind;
      int ch;
      int r;
      logic [31:0] d;
      bit wr;
      bit rd;
      kind = $urandom_range(0, 99);
      ch = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      r  = $urandom_range(0, 3);
      case (r)
        R_CTRL:     d = 32'($urandom_range(0, 15));
        R_PRESCALE: d = 32'($urandom_range(0, 3));
        default:    d = 32'($urandom_range(0, 12));
      endcase
      if ($urandom_range(0, 7) == 0) d = d | ($urandom & 32'hFFFF_FFF0);
      wr = kind < 20;
      rd = (kind >= 12) && (kind < 50);
      if ($urandom_range(0, 599) == 0) step(1, wr, rd, addr(ch, r), d);
      else step(0, wr, rd, addr(ch, r), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
